// File: rtl/bar_graph_pkg.sv
// Shared types and constants for the bar graph redraw sequencer.
// Geometry constants describe where bars sit on the VGA frame.
package bar_graph_pkg;

    localparam int unsigned NumBars  = 8;
    localparam int unsigned IdxW     = 3;
    localparam int unsigned XW       = 9;
    localparam int unsigned YW       = 8;
    localparam int unsigned HeightW  = 8;
    localparam int unsigned ColourW  = 3;
    localparam int unsigned PixCntW  = 11;

    localparam logic [XW-1:0]      BaseX     = 9'd40;
    localparam logic [XW-1:0]      BarPitch  = 9'd10;
    localparam logic [YW-1:0]      BaseY     = 8'd220;
    localparam logic [HeightW-1:0] MaxHeight = 8'd200;
    localparam logic [ColourW-1:0] BarColour = 3'b010;
    localparam logic [ColourW-1:0] BgColour  = 3'b000;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StNext,
        StFinish
    } state_e;

    typedef enum logic {
        PhErase,
        PhDraw
    } phase_e;

    function automatic logic [XW-1:0] bar_x(input logic [IdxW-1:0] idx);
        return BaseX + XW'(idx) * BarPitch;
    endfunction

    function automatic logic [HeightW-1:0] clamp_height(input logic [HeightW-1:0] h);
        return (h > MaxHeight) ? MaxHeight : h;
    endfunction

endpackage

// File: rtl/bar_height_regs.sv
// Per-bar height store: clamps on write, combinational read by bar index.
module bar_height_regs
    import bar_graph_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [IdxW-1:0]    wr_idx,
    input  logic [HeightW-1:0] wr_height,
    input  logic [IdxW-1:0]    rd_idx,
    output logic [HeightW-1:0] rd_height
);

    logic [HeightW-1:0] height_q [NumBars];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumBars; i++) begin
                height_q[i] <= '0;
            end
        end else if (wr_en) begin
            height_q[wr_idx] <= clamp_height(wr_height);
        end
    end

    assign rd_height = height_q[rd_idx];

endmodule

// File: rtl/bar_graph_sequencer.sv
// Sequences the single-bar drawer through an erase pass and a draw pass over
// all bar slots, gating plot so the drawer's terminal coordinate is never shown.
module bar_graph_sequencer
    import bar_graph_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [IdxW-1:0]    wr_idx,
    input  logic [HeightW-1:0] wr_height,
    input  logic               go,
    input  logic               draw_done,
    output logic               draw_resetn,
    output logic               draw_enable,
    output logic [XW-1:0]      draw_start_x,
    output logic [YW-1:0]      draw_start_y,
    output logic [HeightW-1:0] draw_height,
    output logic               plot,
    output logic [ColourW-1:0] colour,
    output logic               busy,
    output logic               done
);

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [PixCntW-1:0]  pix_cnt_q, pix_cnt_d;
    logic [XW-1:0]       start_x_q, start_x_d;
    logic [YW-1:0]       start_y_q, start_y_d;
    logic [HeightW-1:0]  height_q, height_d;
    logic [HeightW-1:0]  bar_height;
    logic [PixCntW-1:0]  plot_limit;

    bar_height_regs u_heights (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_height (wr_height),
        .rd_idx    (idx_q),
        .rd_height (bar_height)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= PhErase;
            idx_q     <= '0;
            pix_cnt_q <= '0;
            start_x_q <= '0;
            start_y_q <= '0;
            height_q  <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            pix_cnt_q <= pix_cnt_d;
            start_x_q <= start_x_d;
            start_y_q <= start_y_d;
            height_q  <= height_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        pix_cnt_d = pix_cnt_q;
        start_x_d = start_x_q;
        start_y_d = start_y_q;
        height_d  = height_q;

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    phase_d = PhErase;
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                start_x_d = bar_x(idx_q);
                start_y_d = BaseY;
                height_d  = (phase_q == PhErase) ? MaxHeight : bar_height;
                pix_cnt_d = '0;
                // Zero-height bars in the draw pass never touch the drawer.
                if (phase_q == PhDraw && bar_height == '0) begin
                    state_d = StNext;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                pix_cnt_d = pix_cnt_q + PixCntW'(1);
                if (draw_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (idx_q != IdxW'(NumBars - 1)) begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StLoad;
                end else if (phase_q == PhErase) begin
                    phase_d = PhDraw;
                    idx_d   = '0;
                    state_d = StLoad;
                end else begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The drawer emits 8*(h+1) pixels then one terminal coordinate at row h+1.
    assign plot_limit = (PixCntW'(height_q) + PixCntW'(1)) << 3;

    assign draw_resetn  = (state_q == StRun);
    assign draw_enable  = (state_q == StRun);
    assign draw_start_x = start_x_q;
    assign draw_start_y = start_y_q;
    assign draw_height  = height_q;
    assign plot         = (state_q == StRun) && (pix_cnt_q < plot_limit);
    assign colour       = (phase_q == PhDraw) ? BarColour : BgColour;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StFinish);

endmodule

// File: doc/bar_graph_sequencer.md
# bar_graph_sequencer

Controller that drives the single-bar pixel drawer through a full redraw of an 8-bar graph. On `go` it first erases every bar slot at full height in the background colour, then redraws each bar at its stored height in the bar colour. It supplies the drawer's start coordinates, height, enable and active-low reset, consumes its `done`, and gates a `plot` strobe to the VGA adapter.

## Interface
- `NUM_BARS`, 8: bar slots; index width 3
- `BASE_X`, 40: x of the leftmost bar
- `BAR_PITCH`, 10: x spacing between bar origins
- `BASE_Y`, 220: bottom row of every bar; the drawer counts upward by decrementing y
- `MAX_HEIGHT`, 200: height used for erase and the clamp limit
- `BAR_COLOUR`, 3'b010: colour in the draw phase
- `BG_COLOUR`, 3'b000: colour in the erase phase
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `wr_en` in 1: height write strobe
- `wr_idx` in 3: bar index for the write
- `wr_height` in 8: height value for the write
- `go` in 1: start a redraw; sampled only in IDLE
- `draw_done` in 1: `done` from the drawer
- `draw_resetn` out 1: active-low clear to the drawer
- `draw_enable` out 1: drawer enable
- `draw_start_x` out 9: drawer start x
- `draw_start_y` out 8: drawer start y
- `draw_height` out 8: drawer height
- `plot` out 1: current drawer coordinate is a valid pixel
- `colour` out 3: pixel colour
- `busy` out 1: redraw in progress
- `done` out 1: one-cycle pulse at end of a redraw

## Operation
- Height store: 8×8-bit. A write with `wr_en` stores `min(wr_height, MAX_HEIGHT)` at `wr_idx`. Writes are accepted in every state. A write to the bar currently in RUN does not affect it, because height is latched in LOAD.
- Phase bit: `ERASE` or `DRAW`. Bar index `idx` runs 0..7 in each phase.
- State machine:
  - IDLE: `draw_resetn`=0, `busy`=0. On `go`: phase←ERASE, idx←0, go to LOAD.
  - LOAD:
    - Latch `draw_start_x` = BASE_X + idx·BAR_PITCH (9-bit), `draw_start_y` = BASE_Y, `draw_height` = MAX_HEIGHT if ERASE, else height[idx].
    - Clear `pix_cnt` (11-bit).
    - Keep `draw_resetn`=0.
    - If phase is DRAW and height is 0, go to NEXT (bar skipped, drawer untouched). Otherwise go to RUN.
  - RUN: `draw_resetn`=1, `draw_enable`=1, `pix_cnt` increments each cycle. When `draw_done`=1, go to NEXT.
  - NEXT: `draw_enable`=0, `draw_resetn`=0.
    - If idx≠7: idx+1, go to LOAD.
    - Else if phase is ERASE: phase←DRAW, idx←0, go to LOAD.
    - Else go to FINISH.
  - FINISH: `done`=1 for one cycle, then IDLE.
- `plot` = (state==RUN) && (pix_cnt < {draw_height+1, 3'b000}). This suppresses the drawer's terminal coordinate at row h+1.
- `colour` = BG_COLOUR in ERASE, BAR_COLOUR in DRAW.
- Reset values:
  - State IDLE, phase ERASE, idx 0, all heights 0, `pix_cnt` 0.
  - Outputs: `draw_resetn`=0, `draw_enable`=0, `draw_start_x`=0, `draw_start_y`=0, `draw_height`=0, `plot`=0, `colour`=0, `busy`=0, `done`=0.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from `draw_done` to outputs.
- `busy`=1 from the cycle after `go` is accepted through FINISH inclusive.
- `go` outside IDLE is ignored and not queued.
- Drawer contract: counts 8·(h+1) pixels with enable high; `draw_done` rises the following cycle.
- Per drawn bar: LOAD 1 + RUN 8·(h+1)+1 + NEXT 1 = 8·(h+1)+3 cycles.
- Per erased bar: 1611 cycles.
- Per skipped bar: 2 cycles.
- `plot` is high for exactly 8·(h+1) cycles per non-skipped bar.
- `reset` mid-operation: on the next edge the block is in IDLE with all reset values, and `draw_resetn`=0 clears the drawer.
- Simultaneous `wr_en` and `go`: the write lands first and is seen by the redraw.

## Structure
- Shared package `bar_graph_pkg`:
  - State enum (IDLE, LOAD, RUN, NEXT, FINISH)
  - Phase enum
  - Width constants: X 9, Y 8, HEIGHT 8, IDX 3, COLOUR 3, PIX_CNT 11
- Sub-module `bar_height_regs`: 8×8 register file with clamp on write and a combinational read port by idx.
- The drawer itself is instantiated at top level, not inside this block.

## Test plan
- Reset, then idle 5 cycles: all outputs match reset values; `go` with `reset`=1 is ignored.
- All heights 0, pulse `go`:
  - 12864 `plot` cycles, all `colour`=0.
  - x origins 40, 50, …, 110.
  - DRAW phase issues no drawer enable.
  - `done` pulses once, then `busy`=0.
- Write height[3]=5, redraw: DRAW phase gives exactly 48 `plot` cycles, `colour`=3'b010, x 70..77, y 220 down to 215; no pixel at y 214.
- Write height[0]=250: read back and draw use 200, giving 1608 DRAW-phase `plot` cycles for bar 0.
- `go` pulsed during RUN: ignored, and no second redraw follows FINISH.
- Assert `reset` mid-RUN in ERASE bar 2: next edge `busy`=0, `draw_enable`=0, `draw_resetn`=0, heights cleared; a following `go` restarts at bar 0 ERASE.
